timer_irq_dev: RTL

- Memory-mapped countdown timer that sits on the CPU's peripheral bus through the system bridge.
- Its `irq` output drives the `interrupt` input of the `mips` top, so it is the interrupt-source end of the CPU interrupt interface.
- Software programs a preset value and a control word. The block counts down and raises an interrupt either once or periodically.

---
 rtl/timer_irq_dev.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/timer_irq_dev.sv
// timer_irq_dev: memory-mapped countdown timer and interrupt source.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only), PSC (optional).
// Optional feature macro: TIMER_PRESCALE_EN adds a 16-bit prescaler (PSC at addr 3).
// Without the macro, addr 3 reads 0 and ignores writes.
module timer_irq_dev #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               irq_flag;

  logic               flag_set;
  logic               flag_clr;
  logic               en_clr;
  logic               tick;
  logic               ctrl_wr;
  logic               preset_wr;

`ifdef TIMER_PRESCALE_EN
  logic [15:0]        psc;
  logic [15:0]        psc_cnt;
  logic [15:0]        psc_cnt_next;
`endif

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);
  assign irq       = ctrl_im & irq_flag;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the count/flag/enable actions for the current state.
  always_comb begin
    state_next = state;
    count_next = count;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    en_clr     = 1'b0;
`ifdef TIMER_PRESCALE_EN
    psc_cnt_next = psc_cnt;
    tick         = (psc_cnt == psc);
`else
    tick         = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (ctrl_en) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        count_next = preset;
`ifdef TIMER_PRESCALE_EN
        psc_cnt_next = '0;
`endif
        state_next = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_cnt_next = tick ? '0 : psc_cnt + 16'd1;
`endif
          if (tick) begin
            // COUNT<=1 expires here, so PRESET=0 times out like PRESET=1 and never wraps.
            if (count > CNT_W'(1)) begin
              count_next = count - CNT_W'(1);
            end else begin
              count_next = '0;
              flag_set   = 1'b1;
              state_next = INT;
            end
          end
        end
      end
      INT: begin
        if (ctrl_mode == 2'd1) begin
          flag_clr   = 1'b1;
          state_next = ctrl_en ? LOAD : IDLE;
        end else begin
          en_clr     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Register file and interrupt flag; CPU CTRL write overrides the FSM EN clear,
  // and an FSM flag set overrides any clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc       <= '0;
      psc_cnt   <= '0;
`endif
    end else begin
      count <= count_next;
`ifdef TIMER_PRESCALE_EN
      psc_cnt <= psc_cnt_next;
      if (we && (addr == 2'd3)) begin
        psc <= wdata[15:0];
      end
`endif
      if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (ctrl_wr) begin
        ctrl_en   <= wdata[0];
        ctrl_mode <= wdata[2:1];
        ctrl_im   <= wdata[3];
      end
      if (preset_wr) begin
        preset <= wdata[CNT_W-1:0];
      end
      if (flag_set) begin
        irq_flag <= 1'b1;
      end else if (flag_clr || ctrl_wr || preset_wr) begin
        irq_flag <= 1'b0;
      end
    end
  end

  // Combinational register read, zero-extended to 32 bits.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
      2'd1: rdata[CNT_W-1:0] = preset;
      2'd2: rdata[CNT_W-1:0] = count;
`ifdef TIMER_PRESCALE_EN
      2'd3: rdata[15:0] = psc;
`endif
      default: rdata = '0;
    endcase
  end

endmodule
